// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass, load-use bubble,
// back-pressure hold, flush squash and a saturating stall counter.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   id_*               : decode slot (valid, reg indices, read data,
//                        immediate, control bundle, load/writeback flags)
//   mem_fwd_*, wb_*    : EX/MEM and writeback bypass buses
//   ex_ready, flush    : execute accept, branch squash
//   ex_*               : registered ID/EX slot
//   stall_out          : decode must hold its instruction
//   stall_cnt          : saturating count of stall cycles
module id_ex_stage #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [2:0]    id_src,
    input  logic [2:0]    id_dst,
    input  logic [W-1:0]  id_rsrc,
    input  logic [W-1:0]  id_rdst,
    input  logic [W-1:0]  id_imm,
    input  logic [CW-1:0] id_ctrl,
    input  logic          id_mem_read,
    input  logic          id_reg_write,
    input  logic          mem_fwd_en,
    input  logic [2:0]    mem_fwd_wa,
    input  logic [W-1:0]  mem_fwd_data,
    input  logic          wb_en,
    input  logic [2:0]    wb_wa,
    input  logic [W-1:0]  wb_data,
    input  logic          ex_ready,
    input  logic          flush,
    output logic          ex_valid,
    output logic [W-1:0]  ex_a,
    output logic [W-1:0]  ex_b,
    output logic [W-1:0]  ex_imm,
    output logic [2:0]    ex_wa,
    output logic [CW-1:0] ex_ctrl,
    output logic          ex_mem_read,
    output logic          ex_reg_write,
    output logic          stall_out,
    output logic [7:0]    stall_cnt
);

    logic          ex_valid_q, ex_valid_d;
    logic [W-1:0]  ex_a_q, ex_a_d;
    logic [W-1:0]  ex_b_q, ex_b_d;
    logic [W-1:0]  ex_imm_q, ex_imm_d;
    logic [2:0]    ex_wa_q, ex_wa_d;
    logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
    logic          ex_mem_read_q, ex_mem_read_d;
    logic          ex_reg_write_q, ex_reg_write_d;
    logic [7:0]    stall_cnt_q, stall_cnt_d;

    logic          load_use;
    logic          hold;
    logic          stall;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;

    always_comb begin
        load_use = id_valid & ex_valid_q & ex_mem_read_q & ex_reg_write_q
                 & ((ex_wa_q == id_src) | (ex_wa_q == id_dst));
        hold     = ex_valid_q & ~ex_ready;
        stall    = ~flush & (load_use | hold);

        // EX/MEM result is younger than WB, so it wins.
        if (mem_fwd_en && mem_fwd_wa == id_src) opa = mem_fwd_data;
        else if (wb_en && wb_wa == id_src)      opa = wb_data;
        else                                    opa = id_rsrc;

        if (mem_fwd_en && mem_fwd_wa == id_dst) opb = mem_fwd_data;
        else if (wb_en && wb_wa == id_dst)      opb = wb_data;
        else                                    opb = id_rdst;
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_a_d         = ex_a_q;
        ex_b_d         = ex_b_q;
        ex_imm_d       = ex_imm_q;
        ex_wa_d        = ex_wa_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_reg_write_d = ex_reg_write_q;

        if (flush || (!hold && load_use)) begin
            // squash or bubble: data fields left as-is, slot invalid
            ex_valid_d     = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_reg_write_d = 1'b0;
        end else if (!hold) begin
            ex_valid_d     = id_valid;
            ex_a_d         = opa;
            ex_b_d         = opb;
            ex_imm_d       = id_imm;
            ex_wa_d        = id_dst;
            ex_ctrl_d      = id_ctrl;
            ex_mem_read_d  = id_valid & id_mem_read;
            ex_reg_write_d = id_valid & id_reg_write;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_imm_q       <= '0;
            ex_wa_q        <= '0;
            ex_ctrl_q      <= '0;
            ex_mem_read_q  <= 1'b0;
            ex_reg_write_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_imm_q       <= ex_imm_d;
            ex_wa_q        <= ex_wa_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_reg_write_q <= ex_reg_write_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign ex_imm       = ex_imm_q;
    assign ex_wa        = ex_wa_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_reg_write = ex_reg_write_q;
    assign stall_out    = stall;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage.
// Scoreboard of expected slots, checked one cycle after drive.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [2:0]  wa;
        logic [7:0]  ctrl;
        logic        mr;
        logic        rw;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_src, id_dst;
    logic [15:0] id_rsrc, id_rdst, id_imm;
    logic [7:0]  id_ctrl;
    logic        id_mem_read, id_reg_write;
    logic        mem_fwd_en;
    logic [2:0]  mem_fwd_wa;
    logic [15:0] mem_fwd_data;
    logic        wb_en;
    logic [2:0]  wb_wa;
    logic [15:0] wb_data;
    logic        ex_ready, flush;
    logic        ex_valid;
    logic [15:0] ex_a, ex_b, ex_imm;
    logic [2:0]  ex_wa;
    logic [7:0]  ex_ctrl;
    logic        ex_mem_read, ex_reg_write;
    logic        stall_out;
    logic [7:0]  stall_cnt;

    int checks = 0;
    int errors = 0;
    slot_t sb[$];
    slot_t got, exp_s, held;

    assign got = {ex_valid, ex_a, ex_b, ex_imm, ex_wa, ex_ctrl,
                  ex_mem_read, ex_reg_write};

    always #5 clk = ~clk;

    id_ex_stage #(.W(16), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
        .id_rsrc(id_rsrc), .id_rdst(id_rdst), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_wa(mem_fwd_wa),
        .mem_fwd_data(mem_fwd_data),
        .wb_en(wb_en), .wb_wa(wb_wa), .wb_data(wb_data),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_wa(ex_wa), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .stall_out(stall_out), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; id_valid = 1'b0; id_src = '0; id_dst = '0;
        id_rsrc = '0; id_rdst = '0; id_imm = '0; id_ctrl = '0;
        id_mem_read = 1'b0; id_reg_write = 1'b0;
        mem_fwd_en = 1'b0; mem_fwd_wa = '0; mem_fwd_data = '0;
        wb_en = 1'b0; wb_wa = '0; wb_data = '0;
        ex_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [2:0] d, input logic [15:0] rs,
                         input logic [15:0] rd, input logic [15:0] im,
                         input logic [7:0] c, input logic mr,
                         input logic rw);
        id_valid = v; id_src = s; id_dst = d; id_rsrc = rs;
        id_rdst = rd; id_imm = im; id_ctrl = c;
        id_mem_read = mr; id_reg_write = rw;
    endtask

    task automatic test_reset();
        idle();
        drive(1, 3, 4, 16'h1234, 16'h5678, 16'h9ABC, 8'hFF, 1, 1);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (got !== '0 || stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got %h cnt %0d exp 0", got, stall_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got %b exp 0", stall_out);
        end
    endtask

    task automatic test_capture();
        do_reset();
        drive(1, 1, 2, 16'h1111, 16'h2222, 16'h0033, 8'h5A, 0, 1);
        sb.push_back('{1'b1, 16'h1111, 16'h2222, 16'h0033, 3'd2,
                       8'h5A, 1'b0, 1'b1});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL capture got %h exp %h", got, exp_s);
        end
        // invalid slot forces load/writeback flags low
        drive(0, 5, 6, 16'h0505, 16'h0606, 16'h0707, 8'hC3, 1, 1);
        sb.push_back('{1'b0, 16'h0505, 16'h0606, 16'h0707, 3'd6,
                       8'hC3, 1'b0, 1'b0});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL capture_invalid got %h exp %h", got, exp_s);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1, 3, 5, 16'h1234, 16'h5555, 16'h0001, 8'h11, 0, 1);
        mem_fwd_en = 1; mem_fwd_wa = 3; mem_fwd_data = 16'hAAAA;
        wb_en = 1; wb_wa = 3; wb_data = 16'hBBBB;
        sb.push_back('{1'b1, 16'hAAAA, 16'h5555, 16'h0001, 3'd5,
                       8'h11, 1'b0, 1'b1});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL bypass_mem_wins got %h exp %h", got, exp_s);
        end
        mem_fwd_en = 0;
        sb.push_back('{1'b1, 16'hBBBB, 16'h5555, 16'h0001, 3'd5,
                       8'h11, 1'b0, 1'b1});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL bypass_wb got %h exp %h", got, exp_s);
        end
        // operand B side, and register 0 is forwardable
        drive(1, 0, 5, 16'h1234, 16'h5555, 16'h0002, 8'h22, 0, 0);
        mem_fwd_en = 1; mem_fwd_wa = 5; mem_fwd_data = 16'hCCCC;
        wb_en = 1; wb_wa = 5; wb_data = 16'hDDDD;
        sb.push_back('{1'b1, 16'h1234, 16'hCCCC, 16'h0002, 3'd5,
                       8'h22, 1'b0, 1'b0});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL bypass_b got %h exp %h", got, exp_s);
        end
        mem_fwd_en = 0; wb_wa = 0; wb_data = 16'h0F0F;
        sb.push_back('{1'b1, 16'h0F0F, 16'h5555, 16'h0002, 3'd5,
                       8'h22, 1'b0, 1'b0});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL bypass_r0 got %h exp %h", got, exp_s);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 1, 4, 16'h0100, 16'h0400, 16'h0010, 8'h80, 1, 1);
        sb.push_back('{1'b1, 16'h0100, 16'h0400, 16'h0010, 3'd4,
                       8'h80, 1'b1, 1'b1});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL load_slot got %h exp %h", got, exp_s);
        end
        // dependent instruction; a stale bypass must not beat the bubble
        drive(1, 4, 6, 16'h0444, 16'h0666, 16'h0020, 8'h01, 0, 1);
        mem_fwd_en = 1; mem_fwd_wa = 4; mem_fwd_data = 16'hDEAD;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got %b exp 1", stall_out);
        end
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000 ||
            stall_cnt !== 8'd1) begin
            errors++;
            $display("FAIL load_use_bubble got %b%b%b cnt %0d exp 000 cnt 1",
                     ex_valid, ex_mem_read, ex_reg_write, stall_cnt);
        end
        mem_fwd_en = 0; wb_en = 1; wb_wa = 4; wb_data = 16'h7777;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL load_use_retry_stall got %b exp 0", stall_out);
        end
        sb.push_back('{1'b1, 16'h7777, 16'h0666, 16'h0020, 3'd6,
                       8'h01, 1'b0, 1'b1});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s || stall_cnt !== 8'd1) begin
            errors++;
            $display("FAIL load_use_retry got %h cnt %0d exp %h cnt 1",
                     got, stall_cnt, exp_s);
        end
        // match on the destination index as well
        idle();
        drive(1, 0, 2, 16'h0, 16'h0, 16'h0, 8'h0, 1, 1);
        tick();
        drive(1, 7, 2, 16'h0, 16'h0, 16'h0, 8'h0, 0, 0);
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL load_use_dst got %b exp 1", stall_out);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        do_reset();
        held = '{1'b1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 3'd3,
                 8'h33, 1'b0, 1'b1};
        drive(1, 1, 3, 16'hA0A0, 16'hB0B0, 16'hC0C0, 8'h33, 0, 1);
        tick();
        drive(1, 2, 7, 16'h1A1A, 16'h2B2B, 16'h3C3C, 8'h77, 0, 1);
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_out !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall[%0d] got %b exp 1", i, stall_out);
            end
            tick();
            checks++;
            if (got !== held) begin
                errors++;
                $display("FAIL hold_slot[%0d] got %h exp %h", i, got, held);
            end
        end
        checks++;
        if (stall_cnt !== 8'd3) begin
            errors++;
            $display("FAIL hold_cnt got %0d exp 3", stall_cnt);
        end
        ex_ready = 1;
        sb.push_back('{1'b1, 16'h1A1A, 16'h2B2B, 16'h3C3C, 3'd7,
                       8'h77, 1'b0, 1'b1});
        tick();
        exp_s = sb.pop_front();
        checks++;
        if (got !== exp_s) begin
            errors++;
            $display("FAIL hold_release got %h exp %h", got, exp_s);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 3, 16'h1, 16'h2, 16'h3, 8'h4, 0, 1);
        tick();
        ex_ready = 0; flush = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold_stall got %b exp 0", stall_out);
        end
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000 ||
            stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flush_hold got %b cnt %0d exp 0 cnt 0",
                     ex_valid, stall_cnt);
        end
        ex_ready = 1; flush = 0;
        drive(1, 1, 4, 16'h1, 16'h2, 16'h3, 8'h4, 1, 1);
        tick();
        drive(1, 4, 5, 16'h1, 16'h2, 16'h3, 8'h4, 0, 1);
        flush = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_lu_stall got %b exp 0", stall_out);
        end
        tick();
        checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000 ||
            stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flush_lu got %b cnt %0d exp 0 cnt 0",
                     ex_valid, stall_cnt);
        end
        flush = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 1, 2, 16'h9, 16'h8, 16'h7, 8'h6, 0, 1);
        tick();
        ex_ready = 0;
        for (int i = 0; i < 255; i++) tick();
        checks++;
        if (stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_255 got %0d exp 255", stall_cnt);
        end
        for (int i = 0; i < 45; i++) tick();
        checks++;
        if (stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_300 got %0d exp 255", stall_cnt);
        end
        // reset in the middle of a hold
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (got !== '0 || stall_cnt !== 8'd0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold got %h cnt %0d st %b exp 0",
                     got, stall_cnt, stall_out);
        end
        // reset in the middle of a bubble
        ex_ready = 1;
        drive(1, 1, 4, 16'h1, 16'h2, 16'h3, 8'h4, 1, 1);
        tick();
        drive(1, 4, 5, 16'h1, 16'h2, 16'h3, 8'h4, 0, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (got !== '0 || stall_cnt !== 8'd0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_bubble got %h cnt %0d st %b exp 0",
                     got, stall_cnt, stall_out);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_capture();
        test_bypass();
        test_load_use();
        test_back_pressure();
        test_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter W, default 16, datapath/register width.
REQ-002 SHALL have parameter CW, default 8, opaque execute control-bundle width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports id_valid  input  1  decode slot holds an instruction; id_src, id_dst  input  3  source/destination register indices.
REQ-006 SHALL have ports id_rsrc, id_rdst  input  W  register-file read data for id_src/id_dst; id_imm  input  W  immediate.
REQ-007 SHALL have ports id_ctrl  input  CW  control bundle; id_mem_read, id_reg_write  input  1  load flag, writeback flag.
REQ-008 SHALL have ports mem_fwd_en  input  1, mem_fwd_wa  input  3, mem_fwd_data  input  W  EX/MEM-stage result bypass.
REQ-009 SHALL have ports wb_en  input  1, wb_wa  input  3, wb_data  input  W  writeback-stage bypass (same data the register file is being written with).
REQ-010 SHALL have ports ex_ready  input  1  execute accepts the current slot; flush  input  1  squash decode slot (branch taken).
REQ-011 SHALL have outputs ex_valid 1, ex_a W, ex_b W, ex_imm W, ex_wa 3, ex_ctrl CW, ex_mem_read 1, ex_reg_write 1: registered ID/EX slot.
REQ-012 SHALL have outputs stall_out  1  decode must hold its instruction; stall_cnt  8  saturating count of stall cycles.

Function
REQ-013 SHALL compute load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_wa==id_src | ex_wa==id_dst), combinationally.
REQ-014 SHALL drive stall_out = load_use | (ex_valid & ~ex_ready), combinationally, masked to 0 while flush=1.
REQ-015 SHALL resolve operand A: mem_fwd_en & mem_fwd_wa==id_src -> mem_fwd_data; else wb_en & wb_wa==id_src -> wb_data; else id_rsrc.
REQ-016 SHALL resolve operand B identically using id_dst/id_rdst; EX/MEM bypass always wins over WB bypass.
REQ-017 SHALL update the slot each rising edge with priority: rst > flush > hold > bubble > capture.
REQ-018 flush: ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0; data fields don't-care; regardless of ex_ready.
REQ-019 hold (ex_valid & ~ex_ready): every slot register keeps its value.
REQ-020 bubble (load_use, ex_ready=1): ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0; stall lasts exactly one cycle per load-use pair.
REQ-021 capture: ex_valid<=id_valid, ex_a/ex_b<=resolved operands, other fields <= id_* inputs; ex_mem_read/ex_reg_write forced 0 when id_valid=0.
REQ-022 Latency SHALL be one cycle from decode inputs to ex_* outputs; no combinational path from id_* to ex_*.
REQ-023 stall_cnt SHALL increment by 1 on each rising edge where stall_out=1, saturating at 255 (no wrap).
REQ-024 Simultaneous bypass and load_use: bubble wins; forwarded value re-resolved on the retry cycle.
REQ-025 Forwarding to register index 0 SHALL NOT be special-cased; all 8 indices are general-purpose.

Reset
REQ-026 On rst=1 at a rising edge: ex_valid, ex_mem_read, ex_reg_write, ex_a, ex_b, ex_imm, ex_wa, ex_ctrl, stall_cnt <= 0.
REQ-027 stall_out SHALL read 0 in the cycle after reset (ex_valid=0), independent of id_* inputs.
REQ-028 rst asserted mid-hold or mid-bubble SHALL discard the slot; no held instruction survives reset.

Verification
REQ-029 Plain capture: id_valid=1, src=1, dst=2, rsrc=0x1111, rdst=0x2222, no bypass -> next cycle ex_valid=1, ex_a=0x1111, ex_b=0x2222.
REQ-030 Bypass priority: src=3, mem_fwd(3,0xAAAA), wb(3,0xBBBB) -> ex_a=0xAAAA; mem_fwd_en=0 -> ex_a=0xBBBB.
REQ-031 Load-use: slot load to R4, next id src=4 -> stall_out=1 one cycle, ex_valid=0 bubble, stall_cnt=1; retry captures with wb bypass.
REQ-032 Back-pressure: ex_ready=0 for 3 cycles -> ex_* unchanged, stall_out=1, stall_cnt +=3; ex_ready=1 -> new capture.
REQ-033 Flush during hold and load_use -> next cycle ex_valid=0, stall_out=0 that cycle, stall_cnt unchanged.
REQ-034 Saturation/reset: force 300 stall cycles -> stall_cnt=255; rst=1 one edge -> all outputs 0.
